dca_tensor_scalar_accumulator: RTL and testbench
================================================

Name: dca_tensor_scalar_accumulator

Overview:
- Downstream stage of the tensor-scalar multiplier. It consumes that block's product stream (valid + BW_SCALAR result) and sums a programmed number of signed integer products into a wide accumulator.
- It emits one reduced sum per group through a valid/ready output register.
- The multiplier has no backpressure, so this block exposes in_ready. The controller uses in_ready to gate the multiplier's enable.

Parameters:
- BW_SCALAR, 32, width of incoming product and of the narrowed output scalar.
- BW_ACC, 48, accumulator width; must be >= BW_SCALAR.
- BW_COUNT, 16, width of the group-length configuration and of the beat counter.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  global advance; when 0, all state and outputs are frozen.
- start  input  1  single-cycle pulse that begins a group.
- cfg_count  input  BW_COUNT  products per group; latched on accepted start.
- cfg_repeat  input  1  when 1, re-arm automatically after each sum is taken; latched on start.
- in_valid  input  1  product valid.
- in_value  input  BW_SCALAR  signed product.
- in_ready  output  1  block is accepting products.
- out_valid  output  1  sum available.
- out_ready  input  1  consumer takes the sum.
- out_acc  output  BW_ACC  full-width signed sum.
- out_scalar  output  BW_SCALAR  narrowed sum.
- out_overflow  output  1  out_acc does not fit in signed BW_SCALAR.
- busy  output  1  state is not IDLE.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - acc=0, cnt=0, out_acc=0, out_scalar=0, out_overflow=0, out_valid=0.
  - in_ready=0, busy=0, latched cfg=0.
  - Reset mid-group discards the partial sum without producing output.
- Beat definition: a beat occurs only when enable=1. Acceptance is in_valid & in_ready & enable.
- IDLE:
  - in_ready=0, out_valid=0.
  - start&enable latches cfg_count and cfg_repeat, and sets acc=0, cnt=0.
  - If cfg_count!=0, go to ACCUM.
  - If cfg_count==0, go to HOLD with out_acc=0 and out_valid=1 on the next cycle.
- ACCUM:
  - in_ready=enable.
  - On each accepted beat: acc += sign-extended in_value; cnt += 1.
  - On the accepted beat where cnt==count-1, in that same edge:
    - out_acc <= acc+in_value;
    - narrow and set out_overflow;
    - go to HOLD.
  - Latency: out_valid is asserted the cycle after the last accepted beat.
  - in_valid=0 beats are ignored; cnt does not advance.
- HOLD:
  - in_ready=0; out_valid=1; out_acc, out_scalar and out_overflow are stable until taken.
  - On out_valid&out_ready&enable:
    - if repeat=1, clear acc and cnt and go to ACCUM (or re-enter HOLD with a zero sum when count==0);
    - otherwise go to IDLE, and out_valid drops the next cycle.
- start is ignored outside IDLE. This includes HOLD with out_ready and start in the same cycle: the block goes to IDLE and start is dropped.
- Arithmetic:
  - two's complement throughout; acc wraps modulo 2^BW_ACC;
  - out_overflow=1 iff out_acc > 2^(BW_SCALAR-1)-1 or out_acc < -2^(BW_SCALAR-1).
- Narrowing (default): out_scalar = out_acc[BW_SCALAR-1:0], i.e. wrap.
- enable=0: no state, counter or output changes. out_valid holds its value, but no handshake completes.

Optional Feature:
- Macro DCA_TENSOR_ACC_SATURATE_EN.
- Defined: out_scalar saturates to 2^(BW_SCALAR-1)-1 or -2^(BW_SCALAR-1) when out_overflow=1; out_acc is unchanged.
- Undefined: out_scalar is the low BW_SCALAR bits (wrap); out_overflow is still reported.

Test Plan:
1. Basic group: rst pulse, start with cfg_count=4 and repeat=0, products 3, -5, 7, 10 back-to-back. Expect out_valid one cycle after the 4th beat, out_acc=15, out_scalar=15, out_overflow=0. After out_ready, busy=0 and in_ready=0.
2. Bubbles and freeze:
   - cfg_count=3, values 1, 2, 4 with in_valid gaps, and enable=0 for 2 cycles mid-group. Expect sum=7; cnt does not advance during gaps or freeze.
   - Stall out_ready for 5 cycles: out_acc stays at 7 and in_ready=0 throughout.
3. Overflow: BW_SCALAR=32, cfg_count=2, values 0x7FFFFFFF and 0x00000001. Expect out_acc=0x80000000 and out_overflow=1.
   - Macro off: out_scalar=0x80000000.
   - Macro on: out_scalar=0x7FFFFFFF.
   - Negative case: values 0x80000000 and 0xFFFFFFFF give saturated 0x80000000 with the macro on.
4. Repeat mode: cfg_count=2, repeat=1, stream 1, 2, 3, 4. Expect sums 3 then 7. in_ready is 0 during each HOLD and returns 1 the cycle after the handshake.
5. Zero count: start with cfg_count=0. Expect out_valid=1 the next cycle with out_acc=0, and no input beats accepted.
6. Reset mid-op and stray start:
   - Assert rst after 2 of 4 beats: all outputs go to 0 and state is IDLE. The next group of 1, 1 with count=2 yields 2, with no residue.
   - start pulsed during ACCUM is ignored; the sum is unchanged.

Source files
------------

// File: rtl/dca_tensor_scalar_accumulator.sv
// Signed reduction stage: sums cfg_count products per group and presents the sum on a valid/ready register.
// Optional build macro DCA_TENSOR_ACC_SATURATE_EN makes out_scalar saturate instead of wrap on overflow.
module dca_tensor_scalar_accumulator #(
   parameter int BW_SCALAR = 32,
   parameter int BW_ACC    = 48,
   parameter int BW_COUNT  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic                 start,
   input  logic [BW_COUNT-1:0]  cfg_count,
   input  logic                 cfg_repeat,
   input  logic                 in_valid,
   input  logic [BW_SCALAR-1:0] in_value,
   output logic                 in_ready,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [BW_ACC-1:0]    out_acc,
   output logic [BW_SCALAR-1:0] out_scalar,
   output logic                 out_overflow,
   output logic                 busy
);

   typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

   state_t                state;
   logic [BW_ACC-1:0]     acc;
   logic [BW_COUNT-1:0]   cnt;
   logic [BW_COUNT-1:0]   count_q;
   logic                  repeat_q;

   logic [BW_ACC-1:0]     ext;
   logic [BW_ACC-1:0]     sum;
   logic [BW_ACC-BW_SCALAR:0] hi;
   logic                  sum_ovf;
   logic [BW_SCALAR-1:0]  sum_scalar;
   logic                  last_beat;

   assign ext       = BW_ACC'($signed(in_value));
   assign sum       = acc + ext;
   // The sum fits in signed BW_SCALAR only when every bit from the scalar sign bit up is identical.
   assign hi        = sum[BW_ACC-1:BW_SCALAR-1];
   assign sum_ovf   = ~((&hi) | ~(|hi));
   assign last_beat = (cnt == count_q - BW_COUNT'(1));

`ifdef DCA_TENSOR_ACC_SATURATE_EN
   assign sum_scalar = !sum_ovf       ? sum[BW_SCALAR-1:0] :
                       sum[BW_ACC-1]  ? {1'b1, {(BW_SCALAR-1){1'b0}}} :
                                        {1'b0, {(BW_SCALAR-1){1'b1}}};
`else
   assign sum_scalar = sum[BW_SCALAR-1:0];
`endif

   assign in_ready = (state == ACCUM) & enable;
   assign busy     = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         acc          <= '0;
         cnt          <= '0;
         count_q      <= '0;
         repeat_q     <= 1'b0;
         out_valid    <= 1'b0;
         out_acc      <= '0;
         out_scalar   <= '0;
         out_overflow <= 1'b0;
      end else if (enable) begin
         case (state)
            IDLE: begin
               if (start) begin
                  count_q  <= cfg_count;
                  repeat_q <= cfg_repeat;
                  acc      <= '0;
                  cnt      <= '0;
                  if (cfg_count != '0) begin
                     state <= ACCUM;
                  end else begin
                     state        <= HOLD;
                     out_valid    <= 1'b1;
                     out_acc      <= '0;
                     out_scalar   <= '0;
                     out_overflow <= 1'b0;
                  end
               end
            end
            ACCUM: begin
               if (in_valid) begin
                  acc <= sum;
                  cnt <= cnt + BW_COUNT'(1);
                  if (last_beat) begin
                     state        <= HOLD;
                     out_valid    <= 1'b1;
                     out_acc      <= sum;
                     out_scalar   <= sum_scalar;
                     out_overflow <= sum_ovf;
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  if (repeat_q) begin
                     acc <= '0;
                     cnt <= '0;
                     // A zero-length group re-presents a zero sum immediately.
                     if (count_q != '0) begin
                        state     <= ACCUM;
                        out_valid <= 1'b0;
                     end else begin
                        out_acc      <= '0;
                        out_scalar   <= '0;
                        out_overflow <= 1'b0;
                     end
                  end else begin
                     state     <= IDLE;
                     out_valid <= 1'b0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dca_tensor_scalar_accumulator.sv
// Directed and randomized groups checked against an arithmetic reference of the reduced sum.
module tb_dca_tensor_scalar_accumulator;
   localparam int BS = 32;
   localparam int BA = 48;
   localparam int BC = 16;

   typedef logic [BS-1:0] vq_t[$];

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          enable = 1'b0;
   logic          start = 1'b0;
   logic [BC-1:0] cfg_count = '0;
   logic          cfg_repeat = 1'b0;
   logic          in_valid = 1'b0;
   logic [BS-1:0] in_value = '0;
   logic          in_ready;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [BA-1:0] out_acc;
   logic [BS-1:0] out_scalar;
   logic          out_overflow;
   logic          busy;

   int total  = 0;
   int passed = 0;
   vq_t q;

   dca_tensor_scalar_accumulator #(.BW_SCALAR(BS), .BW_ACC(BA), .BW_COUNT(BC)) dut (
      .clk(clk), .rst(rst), .enable(enable), .start(start),
      .cfg_count(cfg_count), .cfg_repeat(cfg_repeat),
      .in_valid(in_valid), .in_value(in_value), .in_ready(in_ready),
      .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
      .out_scalar(out_scalar), .out_overflow(out_overflow), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Reference: exact integer sum reduced modulo 2^BA.
   function automatic logic [BA-1:0] model_acc(input vq_t v);
      longint t = 0;
      foreach (v[i]) t += longint'($signed(v[i]));
      return t[BA-1:0];
   endfunction

   function automatic longint as_signed(input logic [BA-1:0] a);
      return longint'($signed(a));
   endfunction

   function automatic logic model_ovf(input logic [BA-1:0] a);
      longint lim = longint'(1) << (BS - 1);
      return (as_signed(a) >= lim) || (as_signed(a) < -lim);
   endfunction

   function automatic logic [BS-1:0] model_scalar(input logic [BA-1:0] a);
      logic [BS-1:0] smax = '1;
`ifdef DCA_TENSOR_ACC_SATURATE_EN
      if (model_ovf(a)) begin
         smax[BS-1] = 1'b0;
         return (as_signed(a) < 0) ? ~smax : smax;
      end
`endif
      return a[BS-1:0];
   endfunction

   task automatic run_group(input string tag, input vq_t vals, input bit gaps,
                            input int freeze_at, input int stray_at, input int stall);
      logic [BA-1:0] ea;
      int n;
      n  = vals.size();
      ea = model_acc(vals);
      enable = 1'b1; start = 1'b1; cfg_count = BC'(n); cfg_repeat = 1'b0;
      tick();
      start = 1'b0;
      check({tag, "/busy"}, 64'(busy), 64'(1));
      for (int i = 0; i < n; i++) begin
         if (gaps && $urandom_range(1, 0) == 1) begin
            in_valid = 1'b0; in_value = $urandom;
            tick();
         end
         if (i == freeze_at) begin
            enable = 1'b0; in_valid = 1'b1; in_value = $urandom;
            #1 check({tag, "/frz_rdy"}, 64'(in_ready), 64'(0));
            repeat (2) tick();
            enable = 1'b1;
         end
         if (i == stray_at) begin
            start = 1'b1; cfg_count = 1;
         end
         in_valid = 1'b1; in_value = vals[i];
         tick();
         start = 1'b0; in_valid = 1'b0;
         if (i < n - 1) check({tag, "/early"}, 64'(out_valid), 64'(0));
      end
      in_valid = 1'b1; in_value = $urandom;
      check({tag, "/ovld"}, 64'(out_valid), 64'(1));
      check({tag, "/rdy"},  64'(in_ready), 64'(0));
      check({tag, "/acc"},  64'(out_acc), 64'(ea));
      check({tag, "/scl"},  64'(out_scalar), 64'(model_scalar(ea)));
      check({tag, "/ovf"},  64'(out_overflow), 64'(model_ovf(ea)));
      repeat (stall) tick();
      check({tag, "/stall_acc"}, 64'(out_acc), 64'(ea));
      check({tag, "/stall_rdy"}, 64'(in_ready), 64'(0));
      enable = 1'b0; out_ready = 1'b1;
      tick();
      check({tag, "/frz_hold"}, 64'(out_valid), 64'(1));
      enable = 1'b1; in_valid = 1'b0;
      tick();
      out_ready = 1'b0;
      check({tag, "/done_vld"}, 64'(out_valid), 64'(0));
      check({tag, "/done_busy"}, 64'(busy), 64'(0));
      check({tag, "/done_rdy"}, 64'(in_ready), 64'(0));
   endtask

   initial begin
      #2;
      check("rst/vld", 64'(out_valid), 64'(0));
      check("rst/acc", 64'(out_acc), 64'(0));
      check("rst/busy", 64'(busy), 64'(0));
      check("rst/rdy", 64'(in_ready), 64'(0));
      #5 rst = 1'b0;
      tick();

      // Basic group
      q.delete(); q.push_back(32'd3); q.push_back(32'hFFFF_FFFB); q.push_back(32'd7); q.push_back(32'd10);
      run_group("basic", q, 1'b0, -1, -1, 0);

      // Bubbles, freeze, stalled consumer
      q.delete(); q.push_back(32'd1); q.push_back(32'd2); q.push_back(32'd4);
      run_group("bubble", q, 1'b1, 1, -1, 5);

      // Positive and negative overflow
      q.delete(); q.push_back(32'h7FFF_FFFF); q.push_back(32'h0000_0001);
      run_group("ovf_pos", q, 1'b0, -1, -1, 1);
      q.delete(); q.push_back(32'h8000_0000); q.push_back(32'hFFFF_FFFF);
      run_group("ovf_neg", q, 1'b0, -1, -1, 1);

      // Zero-length group
      q.delete();
      run_group("zero", q, 1'b0, -1, -1, 2);

      // Repeat mode: 1+2 then 3+4
      start = 1'b1; cfg_count = 2; cfg_repeat = 1'b1;
      tick();
      start = 1'b0; cfg_repeat = 1'b0;
      in_valid = 1'b1; in_value = 1; tick(); in_value = 2; tick(); in_valid = 1'b0;
      check("rep1/acc", 64'(out_acc), 64'(3));
      check("rep1/rdy", 64'(in_ready), 64'(0));
      out_ready = 1'b1; tick(); out_ready = 1'b0;
      check("rep1/rearm_rdy", 64'(in_ready), 64'(1));
      check("rep1/rearm_vld", 64'(out_valid), 64'(0));
      in_valid = 1'b1; in_value = 3; tick(); in_value = 4; tick(); in_valid = 1'b0;
      check("rep2/acc", 64'(out_acc), 64'(7));
      check("rep2/vld", 64'(out_valid), 64'(1));
      out_ready = 1'b1; tick(); out_ready = 1'b0;
      check("rep2/busy", 64'(busy), 64'(1));

      // Reset in the middle of a group
      rst = 1'b1; #1;
      check("mid_rst/vld", 64'(out_valid), 64'(0));
      check("mid_rst/acc", 64'(out_acc), 64'(0));
      check("mid_rst/busy", 64'(busy), 64'(0));
      rst = 1'b0;
      tick();
      start = 1'b1; cfg_count = 4; tick(); start = 1'b0;
      in_valid = 1'b1; in_value = 100; tick(); tick(); in_valid = 1'b0;
      rst = 1'b1; #1;
      check("rst2/vld", 64'(out_valid), 64'(0));
      check("rst2/acc", 64'(out_acc), 64'(0));
      check("rst2/scl", 64'(out_scalar), 64'(0));
      check("rst2/ovf", 64'(out_overflow), 64'(0));
      check("rst2/busy", 64'(busy), 64'(0));
      check("rst2/rdy", 64'(in_ready), 64'(0));
      rst = 1'b0;
      tick();
      q.delete(); q.push_back(32'd1); q.push_back(32'd1);
      run_group("post_rst", q, 1'b0, -1, -1, 0);

      // Stray start during accumulation
      q.delete(); q.push_back(32'd5); q.push_back(32'd6); q.push_back(32'd7);
      run_group("stray", q, 1'b0, -1, 1, 0);

      // Randomized groups
      for (int g = 0; g < 24; g++) begin
         int n;
         n = $urandom_range(6, 0);
         q.delete();
         for (int i = 0; i < n; i++)
            q.push_back(($urandom_range(1, 0) == 1) ? BS'($urandom) : BS'($urandom_range(200, 0) - 100));
         run_group("rand", q, 1'b1, (n > 0) ? int'($urandom_range(n - 1, 0)) : -1,
                   (n > 1) ? int'($urandom_range(n - 1, 0)) : -1, $urandom_range(3, 0));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
